// File: rtl/rv_itcm_loader_pkg.sv
// Shared constants and helpers for the ITCM boot loader.
package rv_itcm_loader_pkg;

    // Default ITCM depth in 32-bit words.
    localparam int ITCM_SIZE = 1024;

    // One ITCM word as assembled from the byte stream.
    typedef logic [31:0] word_t;

    // Number of address bits needed to index 'value' entries.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rv_itcm_loader_if.sv
// Byte-stream input and ITCM port-a write bus of the boot loader.
interface rv_itcm_loader_if
    import rv_itcm_loader_pkg::*;
#(
    parameter int AW = clog2(ITCM_SIZE)
) ();

    logic          rx_valid_i;
    logic [7:0]    rx_data_i;
    logic          rx_ready_o;
    logic          itcm_wena_o;
    logic [3:0]    itcm_strobe_o;
    logic [AW-1:0] itcm_addr_o;
    word_t         itcm_data_o;

    // Loader side: consumes bytes, drives the RAM write port.
    modport master (
        input  rx_valid_i,
        input  rx_data_i,
        output rx_ready_o,
        output itcm_wena_o,
        output itcm_strobe_o,
        output itcm_addr_o,
        output itcm_data_o
    );

    // Environment side: byte source and RAM write port.
    modport slave (
        output rx_valid_i,
        output rx_data_i,
        input  rx_ready_o,
        input  itcm_wena_o,
        input  itcm_strobe_o,
        input  itcm_addr_o,
        input  itcm_data_o
    );

endinterface

// File: rtl/rv_itcm_loader_byte_packer.sv
// Little-endian 4-byte assembler, shared by the header and data phases.
module rv_byte_packer
    import rv_itcm_loader_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear_i,
    input  logic       byte_valid_i,
    input  logic [7:0] byte_i,
    output word_t      word_o,
    output word_t      word_next_o,
    output logic       complete_o
);

    logic [1:0] idx_q, idx_d;
    word_t      word_q, word_d;

    // Place each accepted byte at the lane selected by the index, LSB lane first.
    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        if (clear_i) begin
            word_d = '0;
            idx_d  = '0;
        end else if (byte_valid_i) begin
            word_d[{idx_q, 3'b000} +: 8] = byte_i;
            idx_d = idx_q + 2'd1;
        end
    end

    // Hold the partial word and lane index across arbitrary input stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

    assign word_o      = word_q;
    assign word_next_o = word_d;
    assign complete_o  = byte_valid_i & ~clear_i & (idx_q == 2'd3);

endmodule

// File: rtl/rv_itcm_loader.sv
// Boot-time ITCM writer: length header, then packed program words to address 0 upward.
module rv_itcm_loader
    import rv_itcm_loader_pkg::*;
#(
    parameter  int DEPTH = ITCM_SIZE,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    rv_itcm_loader_if.master bus,
    output logic             cpu_hold_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [AW:0]      words_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN   = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [AW:0] words_q, words_d;
    word_t       len_q, len_d;

    logic        rx_ready;
    logic        byte_fire;
    logic        pack_clear;
    logic        pack_complete;
    word_t       pack_word;
    word_t       pack_word_next;
    logic [AW:0] words_inc;

    assign rx_ready  = (state_q == S_LEN) || (state_q == S_DATA);
    assign byte_fire = bus.rx_valid_i & rx_ready;
    assign words_inc = words_q + (AW+1)'(1);

    rv_byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (pack_clear),
        .byte_valid_i (byte_fire),
        .byte_i       (bus.rx_data_i),
        .word_o       (pack_word),
        .word_next_o  (pack_word_next),
        .complete_o   (pack_complete)
    );

    // Sequence header, data and write phases; start is honoured only when no load is running.
    always_comb begin
        state_d    = state_q;
        words_d    = words_q;
        len_d      = len_q;
        pack_clear = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_i) begin
                    state_d    = S_LEN;
                    words_d    = '0;
                    len_d      = '0;
                    pack_clear = 1'b1;
                end
            end
            S_LEN: begin
                if (pack_complete) begin
                    len_d = pack_word_next;
                    if (pack_word_next == 32'd0) begin
                        state_d = S_DONE;
                    end else if (pack_word_next > 32'(DEPTH)) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (pack_complete) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                words_d = words_inc;
                state_d = (32'(words_inc) == len_q) ? S_DONE : S_DATA;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Register the FSM, the running word count and the captured image length.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            words_q <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            words_q <= words_d;
            len_q   <= len_d;
        end
    end

    assign bus.rx_ready_o    = rx_ready;
    assign bus.itcm_wena_o   = (state_q == S_WRITE);
    assign bus.itcm_strobe_o = (state_q == S_WRITE) ? 4'hF : 4'h0;
    assign bus.itcm_addr_o   = words_q[AW-1:0];
    assign bus.itcm_data_o   = pack_word;

    assign cpu_hold_o = (state_q != S_DONE);
    assign busy_o     = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_WRITE);
    assign done_o     = (state_q == S_DONE);
    assign err_o      = (state_q == S_ERR);
    assign words_o    = words_q;

endmodule

// File: tb/tb_rv_itcm_loader.sv
// Scoreboard bench for the ITCM boot loader with a randomized byte source.
module tb_rv_itcm_loader;
    import rv_itcm_loader_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = clog2(DEPTH);

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        cpu_hold_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [AW:0] words_o;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [31:0] img[$];
    int          checks   = 0;
    int          failures = 0;

    rv_itcm_loader_if #(.AW(AW)) bus ();

    rv_itcm_loader #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .bus        (bus),
        .cpu_hold_o (cpu_hold_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .words_o    (words_o)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Monitor: every write pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (bus.itcm_wena_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_write: got addr=%0d data=%h, required no write",
                         bus.itcm_addr_o, bus.itcm_data_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.itcm_addr_o !== mon_e.addr || bus.itcm_data_o !== mon_e.data ||
                    bus.itcm_strobe_o !== 4'hF) begin
                    failures++;
                    $display("[TB] FAIL write: got addr=%0d data=%h strobe=%h, required addr=%0d data=%h strobe=f",
                             bus.itcm_addr_o, bus.itcm_data_o, bus.itcm_strobe_o, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Compare the status outputs against the model's expectation.
    task automatic checkOutput(input string name, input logic exp_ready, input logic exp_hold,
                               input logic exp_busy, input logic exp_done, input logic exp_err,
                               input logic [AW:0] exp_words);
        logic [AW+10:0] act;
        logic [AW+10:0] exp;
        act = {bus.rx_ready_o, cpu_hold_o, busy_o, done_o, err_o,
               bus.itcm_wena_o, bus.itcm_strobe_o, words_o};
        exp = {exp_ready, exp_hold, exp_busy, exp_done, exp_err, 1'b0, 4'h0, exp_words};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got ready,hold,busy,done,err,wena,strobe,words=%b required %b",
                     name, act, exp);
        end
    endtask

    // Bus address/data must read back as zero right after reset.
    task automatic check_bus_zero(input string name);
        checks++;
        if (bus.itcm_addr_o !== '0 || bus.itcm_data_o !== 32'h0) begin
            failures++;
            $display("[TB] FAIL %s: got addr=%0d data=%h required addr=0 data=00000000",
                     name, bus.itcm_addr_o, bus.itcm_data_o);
        end
    endtask

    // Offer one byte after a random gap; called and returns at a falling edge.
    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        int waited;
        bit ok;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (gap) begin
            bus.rx_valid_i = 1'b0;
            bus.rx_data_i  = 8'($urandom);
            @(negedge clk);
        end
        bus.rx_valid_i = 1'b1;
        bus.rx_data_i  = b;
        ok = 1'b0;
        waited = 0;
        while (!ok && waited < 20) begin
            if (bus.rx_ready_o) ok = 1'b1;
            @(negedge clk);
            waited++;
        end
        bus.rx_valid_i = 1'b0;
        bus.rx_data_i  = 8'($urandom);
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL rx_accept: got no rx_ready_o within 20 cycles, required acceptance of byte %h", b);
        end
    endtask

    // Run one load: header of 'len', then img[] words; the model pushes expected writes.
    task automatic applyStimulus(input string name, input logic [31:0] len, input int max_gap,
                                 input int abort_after, input int poke_word);
        wr_t e;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        checkOutput({name, "_start"}, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        for (int k = 0; k < 4; k++) send_byte(8'(len >> (8 * k)), max_gap);
        if (len == 32'd0) begin
            checkOutput({name, "_empty"}, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
            return;
        end
        if (len > 32'(DEPTH)) begin
            checkOutput({name, "_err"}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0);
            return;
        end
        for (int i = 0; i < int'(len); i++) begin
            if (i == poke_word) begin
                start_i = 1'b1;
                repeat (2) @(negedge clk);
                start_i = 1'b0;
                checkOutput({name, "_poke"}, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, (AW+1)'(i));
            end
            for (int k = 0; k < 4; k++) begin
                if (abort_after == 4 * i + k) begin
                    rst = 1'b1;
                    @(negedge clk);
                    checkOutput({name, "_abort"}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
                    check_bus_zero({name, "_abort_bus"});
                    rst = 1'b0;
                    return;
                end
                if (k == 3) begin
                    e.addr = AW'(i);
                    e.data = img[i];
                    exp_q.push_back(e);
                end
                send_byte(8'(img[i] >> (8 * k)), max_gap);
            end
        end
        @(negedge clk);
        checkOutput({name, "_done"}, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, (AW+1)'(len));
    endtask

    // Fill the image with 'n' random words.
    task automatic fill_random(input int n);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back($urandom);
    endtask

    // Main sequence.
    initial begin
        logic [31:0] rlen;
        rst            = 1'b1;
        start_i        = 1'b0;
        bus.rx_valid_i = 1'b0;
        bus.rx_data_i  = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("reset", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        check_bus_zero("reset_bus");
        rst = 1'b0;
        @(negedge clk);

        img = '{32'h00000013, 32'h0000006F};
        applyStimulus("two_words", 32'd2, 0, -1, -1);

        img.delete();
        applyStimulus("zero_len", 32'd0, 0, -1, -1);

        applyStimulus("too_long", 32'(DEPTH + 1), 1, -1, -1);
        bus.rx_valid_i = 1'b1;
        repeat (3) @(negedge clk);
        bus.rx_valid_i = 1'b0;
        checkOutput("err_hold", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0);

        applyStimulus("high_bits", 32'h0001_0002, 0, -1, -1);

        img = '{32'hDEADBEEF};
        applyStimulus("gappy", 32'd1, 7, -1, -1);

        fill_random(3);
        applyStimulus("rst_mid", 32'd3, 1, 6, -1);
        bus.rx_valid_i = 1'b1;
        repeat (3) @(negedge clk);
        bus.rx_valid_i = 1'b0;
        checkOutput("idle_after_rst", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);

        fill_random(DEPTH);
        applyStimulus("full", 32'(DEPTH), 2, -1, DEPTH / 2);

        for (int r = 0; r < 4; r++) begin
            rlen = 32'($urandom_range(DEPTH, 1));
            fill_random(int'(rlen));
            applyStimulus("random", rlen, 3, -1, -1);
        end

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL pending_writes: got %0d writes still outstanding, required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
